// File: rtl/greater_or_equal_pkg.sv
// Shared ALU definitions: default datapath width and the compare-flags record
// produced by the set/compare path.
package greater_or_equal_pkg;

    localparam int ALU_WIDTH = 32;

    typedef struct packed {
        logic ge;
        logic gt;
        logic same;
    } cmp_flags_t;

endpackage

// File: rtl/greater_or_equal_ge_subtractor.sv
// Full-width subtractor d = a + ~b + 1 with carry, negative, overflow and zero
// flags; combinational, shared with the ALU SUB/SLT path.
module ge_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             c,
    output logic             n,
    output logic             v,
    output logic             z
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        d   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        n   = sum[WIDTH-1];
        // Overflow only when the operands differ in sign and the result sign flips away from a.
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        z   = (sum[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/greater_or_equal.sv
// Registered magnitude comparator: a >= b, a > b, a == b derived from subtractor
// flags, with one cycle of latency and a valid strobe.
module greater_or_equal
    import greater_or_equal_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             same,
    output logic             out_valid
);

    logic [WIDTH-1:0] diff;
    logic             c_flag;
    logic             n_flag;
    logic             v_flag;
    logic             z_flag;

    cmp_flags_t flags_d;
    cmp_flags_t flags_q;
    logic       out_valid_q;

    ge_subtractor #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a (a),
        .b (b),
        .d (diff),
        .c (c_flag),
        .n (n_flag),
        .v (v_flag),
        .z (z_flag)
    );

    always_comb begin
        flags_d      = '0;
        // Signed: N xor V gives "less than"; unsigned: carry out means no borrow.
        flags_d.ge   = SIGNED ? ~(n_flag ^ v_flag) : c_flag;
        flags_d.same = z_flag;
        flags_d.gt   = flags_d.ge & ~z_flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (in_valid) begin
                flags_q <= flags_d;
            end
            out_valid_q <= in_valid;
        end
    end

    assign eq        = flags_q.ge;
    assign gt        = flags_q.gt;
    assign same      = flags_q.same;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_greater_or_equal.sv
// Bench for greater_or_equal: signed and unsigned instances on shared stimulus,
// checked against an arithmetic reference model.
module tb_greater_or_equal;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq_s, gt_s, same_s, ov_s;
    logic         eq_u, gt_u, same_u, ov_u;

    int checks = 0;
    int errors = 0;

    // Expected {eq, gt, same, out_valid} for each instance.
    logic [3:0] exp_s = 4'b0;
    logic [3:0] exp_u = 4'b0;

    always #5 clk = ~clk;

    greater_or_equal #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk (clk), .rst (rst), .in_valid (in_valid), .a (a), .b (b),
        .eq (eq_s), .gt (gt_s), .same (same_s), .out_valid (ov_s)
    );

    greater_or_equal #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk (clk), .rst (rst), .in_valid (in_valid), .a (a), .b (b),
        .eq (eq_u), .gt (gt_u), .same (same_u), .out_valid (ov_u)
    );

    // Reference compare as plain integer arithmetic on 64-bit values.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input bit sgn);
        longint xv, yv;
        if (sgn) begin
            xv = longint'($signed(x));
            yv = longint'($signed(y));
        end else begin
            xv = longint'({32'b0, x});
            yv = longint'({32'b0, y});
        end
        return {xv >= yv, xv > yv, xv == yv};
    endfunction

    function automatic logic [3:0] next_exp(input logic [3:0] cur, input bit r, input bit vl,
                                            input logic [W-1:0] x, input logic [W-1:0] y,
                                            input bit sgn);
        if (r)  return 4'b0;
        if (vl) return {ref_cmp(x, y, sgn), 1'b1};
        return {cur[3:1], 1'b0};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed {eq,gt,same,vld}=%b expected %b", tag, obs, expv);
        end
    endtask

    task automatic step(input bit r, input bit vl, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
        rst      = r;
        in_valid = vl;
        a        = x;
        b        = y;
        @(posedge clk);
        exp_s = next_exp(exp_s, r, vl, x, y, 1'b1);
        exp_u = next_exp(exp_u, r, vl, x, y, 1'b0);
        #1;
        check({tag, "/signed"},   {eq_s, gt_s, same_s, ov_s}, exp_s);
        check({tag, "/unsigned"}, {eq_u, gt_u, same_u, ov_u}, exp_u);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    logic [W-1:0] ra, rb;
    int unsigned  sel;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        // Reset held two cycles with a live operand pair.
        step(1'b1, 1'b1, 32'd5, 32'd3, "reset0");
        step(1'b1, 1'b1, 32'd5, 32'd3, "reset1");
        step(1'b0, 1'b1, 32'd5, 32'd3, "post_reset");
        check_bit("post_reset_eq", eq_s, 1'b1);

        // Signed basic vectors.
        step(1'b0, 1'b1, 32'd1, 32'd2, "s(1,2)");
        check_bit("s(1,2)_eq", eq_s, 1'b0);
        step(1'b0, 1'b1, 32'd2, 32'd1, "s(2,1)");
        step(1'b0, 1'b1, -32'sd2, -32'sd1, "s(-2,-1)");
        check_bit("s(-2,-1)_eq", eq_s, 1'b0);
        step(1'b0, 1'b1, -32'sd1, -32'sd2, "s(-1,-2)");
        step(1'b0, 1'b1, 32'd0, 32'd0, "s(0,0)");
        check_bit("s(0,0)_same", same_s, 1'b1);
        step(1'b0, 1'b1, -32'sd2, 32'd1, "s(-2,1)");
        step(1'b0, 1'b1, 32'd2, -32'sd1, "s(2,-1)");
        check_bit("s(2,-1)_eq", eq_s, 1'b1);
        step(1'b0, 1'b1, 32'd1, -32'sd2, "s(1,-2)");
        step(1'b0, 1'b1, -32'sd1, 32'd2, "s(-1,2)");
        step(1'b0, 1'b1, 32'd1, 32'd1, "s(1,1)");
        step(1'b0, 1'b1, -32'sd1, -32'sd1, "s(-1,-1)");

        // Overflow corners.
        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, "ovf_min_max");
        check_bit("ovf_min_max_eq", eq_s, 1'b0);
        check_bit("ovf_min_max_u_eq", eq_u, 1'b1);
        step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, "ovf_max_min");
        check_bit("ovf_max_min_gt", gt_s, 1'b1);
        step(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, "ovf_min_min");

        // Unsigned-relevant patterns.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, "u(ffffffff,1)");
        check_bit("u(ffffffff,1)_eq", eq_u, 1'b1);
        check_bit("s(ffffffff,1)_eq", eq_s, 1'b0);
        step(1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, "u(1,ffffffff)");
        check_bit("u(1,ffffffff)_eq", eq_u, 1'b0);

        // Valid gating: result holds while the bus is idle.
        step(1'b0, 1'b1, 32'd2, 32'd1, "gate_on");
        step(1'b0, 1'b0, 32'd1, 32'd2, "gate_off");
        check_bit("gate_off_eq", eq_s, 1'b1);
        check_bit("gate_off_vld", ov_s, 1'b0);

        // Back-to-back stream with reset landing on the third edge.
        step(1'b0, 1'b1, 32'd3, 32'd4, "b2b0");
        step(1'b0, 1'b1, 32'd4, 32'd3, "b2b1");
        step(1'b1, 1'b1, 32'd4, 32'd4, "b2b_rst");
        check_bit("b2b_rst_vld", ov_s, 1'b0);

        // Randomized traffic, biased toward sign-boundary operands.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = ra;
            if (sel == 1) ra = {~rb[31], rb[30:0]};
            if (sel == 2) begin ra = 32'h8000_0000; rb = $urandom_range(0, 3); end
            if (sel == 3) ra = rb + 32'd1;
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/greater_or_equal.md
Name: greater_or_equal

Overview:
- Registered magnitude comparator. Asserts eq when operand a is greater than or equal to operand b.
- Default interpretation is signed two's complement; unsigned is selectable by parameter.
- Used by the ALU's set/compare datapath. Result is produced from a full-width subtraction with overflow correction, not from a behavioural relational operator.
- Output is registered: one cycle of latency, with a valid strobe.

Parameters:
- WIDTH, 32, operand width in bits (>= 2).
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned compare.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a/b are valid this cycle.
- a  input  WIDTH  left operand.
- b  input  WIDTH  right operand.
- eq  output  1  registered result: 1 when a >= b under the selected interpretation.
- gt  output  1  registered: 1 when a > b.
- same  output  1  registered: 1 when a == b.
- out_valid  output  1  eq/gt/same correspond to the operands sampled one cycle earlier.

Behaviour:
- Reset: on a rising clk edge with rst=1, eq, gt, same and out_valid all clear to 0. rst has priority over in_valid in the same cycle.
- Datapath, combinational before the register:
  - Compute d = a + ~b + 1 over WIDTH bits, with carry-out c.
  - n = d[WIDTH-1].
  - v = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).
  - z = (d == 0).
- Signed ge = ~(n ^ v). Unsigned ge = c (no borrow).
- same = z. gt = ge & ~z.
- Register stage:
  - When in_valid=1 and rst=0, capture ge, gt and same into eq, gt and same; set out_valid=1.
  - When in_valid=0, hold eq, gt and same at their previous values; clear out_valid to 0.
- Latency: exactly 1 cycle. Throughput: one compare per cycle. No stall or backpressure.
- Boundaries, signed, WIDTH=32:
  - a=-2^31, b=2^31-1 gives eq=0 (overflow case).
  - a=2^31-1, b=-2^31 gives eq=1.
  - a=b=-2^31 gives eq=1, same=1, gt=0.
  - a=0, b=0 gives eq=1.
- Unsigned mode: a=0xFFFFFFFF, b=1 gives eq=1. The same bit patterns in signed mode give eq=0.
- No X propagation from an idle bus: outputs hold their values when in_valid=0.
- Reset asserted mid-stream discards the in-flight result. out_valid is 0 on the cycle after reset.

Decomposition:
- Shared ALU package holds:
  - the default width constant ALU_WIDTH=32;
  - a typedef for a compare-flags record (ge, gt, same).
- One natural sub-module: ge_subtractor. It is purely combinational, takes a and b, and returns d, c, n, v, z. Keep it reusable by the ALU's SUB/SLT path.
- The top level adds the SIGNED select and the output register.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=5, b=3. Required: eq=gt=same=out_valid=0. After release, the next in_valid sample appears one cycle later.
- Signed basic vectors, one per cycle, checking eq one cycle later:
  - (1,2) gives 0; (2,1) gives 1.
  - (-2,-1) gives 0; (-1,-2) gives 1.
  - (0,0) gives 1; (-2,1) gives 0.
  - (2,-1) gives 1; (1,-2) gives 1.
  - (-1,2) gives 0; (1,1) gives 1; (-1,-1) gives 1.
  - same=1 only for (0,0), (1,1) and (-1,-1).
- Overflow corners, signed:
  - (0x80000000, 0x7FFFFFFF) gives eq=0, gt=0.
  - (0x7FFFFFFF, 0x80000000) gives eq=1, gt=1.
  - (0x80000000, 0x80000000) gives eq=1, same=1.
- Unsigned instance (SIGNED=0):
  - (0xFFFFFFFF, 1) gives eq=1.
  - (1, 0xFFFFFFFF) gives eq=0.
  - (0, 0) gives eq=1, same=1.
- Valid gating: apply (2,1) with in_valid=1, then (1,2) with in_valid=0. Required: out_valid goes 1 then 0, and eq stays 1 while in_valid=0.
- Back-to-back plus reset: stream (3,4), (4,3), (4,4), with rst=1 on the third edge. Required: eq=0, then 1, then out_valid=0 and eq=0 after the reset edge.
